cordic_cos_unroll4: RTL and testbench

Fixed-latency CORDIC cosine accelerator, packaged as a multi-cycle custom-instruction slave for the soft CPU. It takes an IEEE-754 single-precision angle in radians and converts it to fixed point. It then runs 20 rotation-mode CORDIC iterations, unrolled 4 per clock, and returns cos(angle) as a signed fixed-point word, signalled by a one-cycle `done` pulse.

---
 rtl/cordic_cos_unroll4.sv | 149 ++++++++++++++
 tb/tb_cordic_cos_unroll4.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_cos_unroll4.sv
// Fixed-latency CORDIC cosine: float angle in, Q11.20 cos out after six enabled
// edges; twenty rotation-mode iterations, four chained per clock.
module cordic_cos_unroll4 (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic {IDLE, COMPUTE} state_t;

  localparam logic signed [31:0] K_INIT    = 32'sh0026_DD3B;
  localparam logic        [2:0]  LAST_STEP = 3'd4;

  state_t             state, state_next;
  logic [2:0]         step, step_next;
  logic               load, advance, finish;
  logic signed [31:0] x, y, z;
  logic signed [31:0] xs [5];
  logic signed [31:0] ys [5];
  logic signed [31:0] zs [5];
  logic signed [31:0] x_round;
  logic [4:0]         sh_base;

  // The sign bit is dropped on purpose: cos is even.
  logic unused_sign;
  assign unused_sign = dataa[31];

  function automatic logic signed [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:  return 32'sh0032_43F7;
      5'd1:  return 32'sh001D_AC67;
      5'd2:  return 32'sh000F_ADBB;
      5'd3:  return 32'sh0007_F56F;
      5'd4:  return 32'sh0003_FEAB;
      5'd5:  return 32'sh0001_FFD5;
      5'd6:  return 32'sh0000_FFFB;
      5'd7:  return 32'sh0000_7FFF;
      5'd8:  return 32'sh0000_4000;
      5'd9:  return 32'sh0000_2000;
      5'd10: return 32'sh0000_1000;
      5'd11: return 32'sh0000_0800;
      5'd12: return 32'sh0000_0400;
      5'd13: return 32'sh0000_0200;
      5'd14: return 32'sh0000_0100;
      5'd15: return 32'sh0000_0080;
      5'd16: return 32'sh0000_0040;
      5'd17: return 32'sh0000_0020;
      5'd18: return 32'sh0000_0010;
      5'd19: return 32'sh0000_0008;
      default: return 32'sh0000_0000;
    endcase
  endfunction

  // Magnitude of the float as Q9.22; value = {1,mant} * 2^(exp-150), i.e. a
  // shift of {1,mant} by (exp-128) once the 22 fraction bits are applied.
  function automatic logic signed [31:0] to_fixed(input logic [30:0] mag);
    logic [7:0]  e;
    logic [31:0] m;
    e = mag[30:23];
    m = {8'd0, 1'b1, mag[22:0]};
    if (e == 8'd0)   return '0;
    if (e >= 8'd128) return $signed(m << (e - 8'd128));
    return $signed(m >> (8'd128 - e));
  endfunction

  assign sh_base = {step, 2'b00};

  // Four chained iterations; shift amount and table index are sh_base + k.
  always_comb begin
    xs[0] = x;
    ys[0] = y;
    zs[0] = z;
    for (int k = 0; k < 4; k++) begin
      if (!zs[k][31]) begin
        xs[k+1] = xs[k] - (ys[k] >>> (sh_base + 5'(k)));
        ys[k+1] = ys[k] + (xs[k] >>> (sh_base + 5'(k)));
        zs[k+1] = zs[k] - atan_lut(sh_base + 5'(k));
      end else begin
        xs[k+1] = xs[k] + (ys[k] >>> (sh_base + 5'(k)));
        ys[k+1] = ys[k] - (xs[k] >>> (sh_base + 5'(k)));
        zs[k+1] = zs[k] + atan_lut(sh_base + 5'(k));
      end
    end
    x_round = (xs[4] + 32'sd2) >>> 2;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    step_next  = step;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    if (start) begin
      load       = 1'b1;
      state_next = COMPUTE;
      step_next  = 3'd0;
    end else if (state == COMPUTE) begin
      advance = 1'b1;
      if (step == LAST_STEP) begin
        finish     = 1'b1;
        state_next = IDLE;
        step_next  = 3'd0;
      end else begin
        step_next = step + 3'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state <= IDLE;
      step  <= 3'd0;
    end else if (clk_en) begin
      state <= state_next;
      step  <= step_next;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      x      <= '0;
      y      <= '0;
      z      <= '0;
      result <= '0;
      done   <= 1'b0;
    end else if (clk_en) begin
      done <= finish;
      if (load) begin
        x <= K_INIT;
        y <= '0;
        z <= to_fixed(dataa[30:0]);
      end else if (advance) begin
        x <= xs[4];
        y <= ys[4];
        z <= zs[4];
      end
      if (finish) result <= x_round;
    end
  end

endmodule

// File: tb/tb_cordic_cos_unroll4.sv
// Self-checking bench for cordic_cos_unroll4: directed and random angles checked
// against real-valued cos(), plus latency, clock-enable, reset and restart.
module tb_cordic_cos_unroll4;

  logic        clock = 1'b0;
  logic        aclr, clk_en, start;
  logic [31:0] dataa, result;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cordic_cos_unroll4 dut (
    .clock  (clock),
    .aclr   (aclr),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .result (result),
    .done   (done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference: decode the IEEE-754 value into a real and take round(cos*2^20).
  function automatic int ref_cos(input logic [31:0] b);
    real a;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) a = 0.0;
    else a = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    return $rtoi($floor($cos(a) * 1048576.0 + 0.5));
  endfunction

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] observed,
                            input int expected);
    int diff;
    diff = $signed(observed) - expected;
    if (diff < 0) diff = -diff;
    checks++;
    assert (diff <= 4) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+-4", tag, $signed(observed), expected);
    end
  endtask

  // Called at a falling edge; drives start now and returns at the falling edge
  // where done is first seen (lat = enabled+disabled edges since start, 0 = timeout).
  task automatic run_job(input logic [31:0] bits, input int pause_at,
                         input int pause_len, output logic [31:0] res,
                         output int lat);
    dataa  = bits;
    start  = 1'b1;
    clk_en = 1'b1;
    lat    = 0;
    res    = '0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        lat = n;
        res = result;
      end else if (pause_len > 0 && n == pause_at) begin
        clk_en = 1'b0;
      end else if (pause_len > 0 && n == pause_at + pause_len) begin
        clk_en = 1'b1;
      end
    end
  endtask

  logic [31:0] sweep_bits [10] = '{32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A,
                                   32'h3ECCCCCD, 32'h3F000000, 32'h3F19999A,
                                   32'h3F333333, 32'h3F4CCCCD, 32'h3F666666,
                                   32'h3F800000};

  initial begin
    logic [31:0] res, res_zero, res_half, res_one, bits;
    int          lat, n_done, first_done;

    aclr   = 1'b1;
    clk_en = 1'b0;
    start  = 1'b0;
    dataa  = '0;
    #12;
    check("reset_result", result, 32'h0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    aclr = 1'b0;
    @(negedge clock);

    // Zero angle, then done holds while disabled and clears on the next enabled edge.
    run_job(32'h0000_0000, 0, 0, res_zero, lat);
    check("zero_lat", 32'(lat), 32'd6);
    check_near("zero_cos", res_zero, ref_cos(32'h0));
    clk_en = 1'b0;
    @(negedge clock);
    check("done_hold", {31'd0, done}, 32'd1);
    clk_en = 1'b1;
    @(negedge clock);
    check("done_clear", {31'd0, done}, 32'd0);
    check("result_hold", result, res_zero);

    run_job(32'h0000_0123, 0, 0, res, lat);
    check("denorm_lat", 32'(lat), 32'd6);
    check("denorm_eq_zero", res, res_zero);

    // Sweep 0.1..1.0, each start issued in the cycle done is high.
    for (int i = 0; i < 10; i++) begin
      run_job(sweep_bits[i], 0, 0, res, lat);
      check($sformatf("sweep%0d_lat", i), 32'(lat), 32'd6);
      check_near($sformatf("sweep%0d_cos", i), res, ref_cos(sweep_bits[i]));
      if (i == 4) res_half = res;
      if (i == 9) res_one = res;
    end

    run_job(32'hBF00_0000, 0, 0, res, lat);
    check("neg_half_eq", res, res_half);
    check_near("neg_half_cos", res, ref_cos(32'h3F00_0000));

    for (int i = 0; i < 8; i++) begin
      bits = {1'($urandom_range(1, 0)), 8'($urandom_range(126, 100)), 23'($urandom)};
      run_job(bits, 0, 0, res, lat);
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'd6);
      check_near($sformatf("rand%0d_cos_%h", i, bits), res, ref_cos(bits));
    end

    // Three disabled cycles mid-job stretch latency by exactly three.
    run_job(32'h3F00_0000, 2, 3, res, lat);
    check("pause_lat", 32'(lat), 32'd9);
    check("pause_result", res, res_half);

    // Asynchronous clear mid-job: outputs drop at once, no done follows.
    dataa = 32'h3F80_0000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 aclr = 1'b1;
    #1;
    check("aclr_result", result, 32'h0);
    check("aclr_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    aclr   = 1'b0;
    n_done = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      if (done) n_done++;
    end
    check("aclr_no_done", 32'(n_done), 32'd0);
    run_job(32'h3F80_0000, 0, 0, res, lat);
    check("post_aclr_lat", 32'(lat), 32'd6);
    check("post_aclr_result", res, res_one);

    // Restart with 1.0 while the 0.5 job sits at step 2.
    @(negedge clock);
    dataa = 32'h3F00_0000;
    start = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clock);
      start = 1'b0;
    end
    dataa      = 32'h3F80_0000;
    start      = 1'b1;
    n_done     = 0;
    first_done = 0;
    res        = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = n;
          res        = result;
        end
      end
    end
    check("restart_count", 32'(n_done), 32'd1);
    check("restart_lat", 32'(first_done), 32'd6);
    check("restart_result", res, res_one);
    check_near("restart_cos", res, ref_cos(32'h3F80_0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
